// File: rtl/execute_divider_iter.sv
// rtl/execute_divider_iter.sv - iterative restoring divider for DIV/DIVU/REM/REMU, UNROLL bits per cycle
module execute_divider_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            clear,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy
);

  localparam int ITER = XLEN / UNROLL;
  localparam int CW   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  if ((XLEN != 32 && XLEN != 64) ||
      (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) ||
      (XLEN % UNROLL != 0)) begin : g_bad_params
    $error("execute_divider_iter: illegal XLEN/UNROLL combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_n;

  logic            rem_sel_q;
  logic            neg_q_q, neg_r_q;
  logic [XLEN-1:0] dvs_q, quo_q;
  logic [XLEN:0]   rem_q;
  logic [CW-1:0]   cnt_q;

  // Operand decode in IDLE: magnitudes, result signs and early-out detection
  logic            is_signed_in, a_neg, b_neg, div_zero, overflow, special, start;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  always_comb begin
    is_signed_in = ~op[0];
    a_neg        = is_signed_in & rdata1[XLEN-1];
    b_neg        = is_signed_in & rdata2[XLEN-1];
    a_abs        = a_neg ? -rdata1 : rdata1;
    b_abs        = b_neg ? -rdata2 : rdata2;
    div_zero     = (rdata2 == '0);
    overflow     = is_signed_in && (rdata1 == MIN) && (rdata2 == '1);
    special      = div_zero | overflow;
    start        = (state_q == IDLE) && enable && !clear;
    if (div_zero) special_res = op[1] ? rdata1 : '1;
    else          special_res = op[1] ? '0 : MIN;
  end

  // UNROLL restoring steps: shift the next dividend bit in, subtract if it fits
  logic [XLEN:0]   rem_n, trial;
  logic [XLEN-1:0] quo_n, q_fin, r_fin, normal_res;

  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    trial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      trial = {rem_n[XLEN-1:0], quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        rem_n    = trial - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end else begin
        rem_n = trial;
      end
    end
    q_fin      = neg_q_q ? -quo_n : quo_n;
    r_fin      = neg_r_q ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
    normal_res = rem_sel_q ? r_fin : q_fin;
  end

  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[XLEN];

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (enable && !clear) state_n = special ? DONE : RUN;
      RUN:     if (clear)                 state_n = IDLE;
               else if (cnt_q == CW'(1))  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == DONE) && !clear;
    busy  = (state_q == RUN) || (state_q == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
    end else begin
      if (start) begin
        rem_sel_q <= op[1];
        neg_q_q   <= a_neg ^ b_neg;
        neg_r_q   <= a_neg;
        dvs_q     <= b_abs;
        quo_q     <= a_abs;
        rem_q     <= '0;
        cnt_q     <= CW'(ITER);
        if (special) result <= special_res;
      end else if (state_q == RUN) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q - CW'(1);
        if (!clear && cnt_q == CW'(1)) result <= normal_res;
      end
    end
  end

endmodule

// File: tb/tb_execute_divider_iter.sv
// tb/tb_execute_divider_iter.sv - vector table, corner sequences and randomised model check for the divider
module tb_execute_divider_iter;

  logic        clock = 1'b0;
  logic        reset, clear, en0, en1, en2;
  logic [1:0]  op_in;
  logic [63:0] a_in, b_in;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic        rdy0, rdy1, rdy2, busy0, busy1, busy2;

  always #5 clock = ~clock;

  execute_divider_iter #(.XLEN(32), .UNROLL(1)) u0 (
    .clock(clock), .reset(reset), .enable(en0), .op(op_in), .rdata1(a_in[31:0]),
    .rdata2(b_in[31:0]), .clear(clear), .result(res0), .ready(rdy0), .busy(busy0));
  execute_divider_iter #(.XLEN(32), .UNROLL(4)) u1 (
    .clock(clock), .reset(reset), .enable(en1), .op(op_in), .rdata1(a_in[31:0]),
    .rdata2(b_in[31:0]), .clear(clear), .result(res1), .ready(rdy1), .busy(busy1));
  execute_divider_iter #(.XLEN(64), .UNROLL(8)) u2 (
    .clock(clock), .reset(reset), .enable(en2), .op(op_in), .rdata1(a_in),
    .rdata2(b_in), .clear(clear), .result(res2), .ready(rdy2), .busy(busy2));

  int cur_sel = 0;
  int checks = 0;
  int errors = 0;
  int xl_of[3] = '{32, 32, 64};
  int ul_of[3] = '{1, 4, 8};

  logic        ready_m, busy_m;
  logic [63:0] result_m;
  assign ready_m  = (cur_sel == 0) ? rdy0 : (cur_sel == 1) ? rdy1 : rdy2;
  assign busy_m   = (cur_sel == 0) ? busy0 : (cur_sel == 1) ? busy1 : busy2;
  assign result_m = (cur_sel == 0) ? {32'd0, res0} : (cur_sel == 1) ? {32'd0, res1} : res2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_en(input int sel, input logic v);
    case (sel)
      0:       en0 = v;
      1:       en1 = v;
      default: en2 = v;
    endcase
  endtask

  function automatic logic [63:0] mask_of(input int xl);
    return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] min_of(input int xl);
    return (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
  endfunction

  // RISC-V M semantics via native signed/unsigned arithmetic plus the two architected special cases
  function automatic logic [63:0] ref_div(input int xl, input logic [1:0] o,
                                          input logic [63:0] a0, input logic [63:0] b0);
    logic [63:0] mask, min, a, b;
    longint sa, sb;
    mask = mask_of(xl);
    min  = min_of(xl);
    a = a0 & mask;
    b = b0 & mask;
    sa = (xl == 64) ? longint'(a) : longint'($signed(a[31:0]));
    sb = (xl == 64) ? longint'(b) : longint'($signed(b[31:0]));
    if (b == 64'd0) return o[1] ? a : mask;
    if (!o[0]) begin
      if (a == min && b == mask) return o[1] ? 64'd0 : min;
      return (o[1] ? 64'(sa % sb) : 64'(sa / sb)) & mask;
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input int sel, input logic [1:0] o,
                                 input logic [63:0] a0, input logic [63:0] b0);
    logic [63:0] mask;
    mask = mask_of(xl_of[sel]);
    if ((b0 & mask) == 64'd0) return 1;
    if (!o[0] && (a0 & mask) == min_of(xl_of[sel]) && (b0 & mask) == mask) return 1;
    return xl_of[sel] / ul_of[sel] + 1;
  endfunction

  // Issue one operation; lat counts clock edges from the enable-sampled cycle to the ready cycle
  task automatic run_op(input int sel, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input bit hold,
                        output logic [63:0] res, output int lat);
    cur_sel = sel;
    @(posedge clock); #1;
    op_in = o; a_in = a; b_in = b;
    set_en(sel, 1'b1);
    lat = 999;
    res = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (!hold) set_en(sel, 1'b0);
      if (k == 1) begin
        a_in = ~a;
        b_in = {$urandom, $urandom};
      end
      if (ready_m) begin
        lat = k;
        res = result_m;
        break;
      end
    end
    if (hold) begin
      int extra;
      extra = 0;
      @(posedge clock); #1;
      set_en(sel, 1'b0);
      for (int k = 0; k < 12; k++) begin
        if (ready_m) extra++;
        @(posedge clock); #1;
      end
      chk("hold_extra_ready", 64'(extra), 64'd0);
      chk("hold_busy_after", {63'd0, busy_m}, 64'd0);
    end
  endtask

  typedef struct {
    int          sel;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [63:0] pick(input int xl);
    logic [63:0] m;
    m = mask_of(xl);
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return m;
      3:       return min_of(xl);
      4:       return 64'($urandom_range(0, 300));
      5:       return (64'd0 - 64'($urandom_range(1, 300))) & m;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    int          lat, seen;
    logic [1:0]  o;
    logic [63:0] a, b;

    vecs[0]  = '{0, 2'b00, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33};
    vecs[1]  = '{0, 2'b10, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 33};
    vecs[2]  = '{1, 2'b01, 64'd100, 64'd7, 64'd14, 9};
    vecs[3]  = '{1, 2'b11, 64'd100, 64'd7, 64'd2, 9};
    vecs[4]  = '{1, 2'b00, 64'h1234_5678, 64'd0, 64'hFFFF_FFFF, 1};
    vecs[5]  = '{1, 2'b11, 64'h1234_5678, 64'd0, 64'h1234_5678, 1};
    vecs[6]  = '{1, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1};
    vecs[7]  = '{1, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    vecs[8]  = '{2, 2'b00, 64'h8000_0000_0000_0001, 64'd3, 64'hD555_5555_5555_5556, 9};
    vecs[9]  = '{2, 2'b01, 64'd0, 64'd5, 64'd0, 9};
    vecs[10] = '{0, 2'b11, 64'd7, 64'hFFFF_FFFF, 64'd7, 33};

    reset = 1'b0; clear = 1'b0; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    op_in = 2'b00; a_in = '0; b_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", {res0, res1} | res2, 64'd0);
    chk("reset_ready", {61'd0, rdy0, rdy1, rdy2}, 64'd0);
    chk("reset_busy", {61'd0, busy0, busy1, busy2}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    run_op(1, 2'b01, 64'd100, 64'd7, 1'b1, r, lat);
    chk("hold_result", r, 64'd14);
    chk("hold_latency", 64'(lat), 64'd9);

    // clear in RUN cycle 10, then a fresh op issued in cycle 12
    cur_sel = 0;
    @(posedge clock); #1;
    op_in = 2'b00; a_in = 64'd1000; b_in = 64'd3; en0 = 1'b1;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      en0 = 1'b0;
      if (rdy0) seen++;
    end
    clear = 1'b1;
    #1;
    chk("clear_run_busy_c10", {63'd0, busy0}, 64'd1);
    chk("clear_run_ready_c10", {63'd0, rdy0}, 64'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clear_run_busy_c11", {63'd0, busy0}, 64'd0);
    chk("clear_run_no_ready", 64'(seen) | {63'd0, rdy0}, 64'd0);
    chk("clear_keeps_result", {32'd0, res0}, 64'd7);
    run_op(0, 2'b01, 64'd9, 64'd3, 1'b0, r, lat);
    chk("after_clear_result", r, 64'd3);
    chk("after_clear_latency", 64'(lat), 64'd33);

    // clear during a DONE cycle suppresses ready
    cur_sel = 1;
    @(posedge clock); #1;
    op_in = 2'b00; a_in = 64'h55; b_in = 64'd0; en1 = 1'b1;
    @(posedge clock); #1;
    en1 = 1'b0; clear = 1'b1;
    #1;
    chk("clear_done_ready", {63'd0, rdy1}, 64'd0);
    chk("clear_done_busy", {63'd0, busy1}, 64'd1);
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clear_done_busy_next", {63'd0, busy1}, 64'd0);
    chk("clear_done_result", {32'd0, res1}, 64'hFFFF_FFFF);

    // clear with enable in IDLE must not start
    en1 = 1'b1; clear = 1'b1; a_in = 64'd100; b_in = 64'd7;
    @(posedge clock); #1;
    en1 = 1'b0; clear = 1'b0;
    chk("clear_idle_no_start", {62'd0, busy1, rdy1}, 64'd0);

    // reset asserted in RUN cycle 5
    cur_sel = 0;
    @(posedge clock); #1;
    op_in = 2'b01; a_in = 64'd12345; b_in = 64'd11; en0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      en0 = 1'b0;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("midreset_state", {res0, 30'd0, rdy0, busy0}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (rdy0 || busy0) seen++;
      @(posedge clock); #1;
    end
    chk("midreset_no_stale", 64'(seen), 64'd0);

    for (int sel = 0; sel < 3; sel++) begin
      for (int n = 0; n < ((sel == 0) ? 40 : 150); n++) begin
        o = 2'($urandom_range(0, 3));
        a = pick(xl_of[sel]);
        b = pick(xl_of[sel]);
        run_op(sel, o, a, b, 1'b0, r, lat);
        chk($sformatf("rand_s%0d_op%0d_%h_%h_result", sel, o, a, b), r, ref_div(xl_of[sel], o, a, b));
        chk($sformatf("rand_s%0d_latency", sel), 64'(lat), 64'(ref_lat(sel, o, a, b)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
